// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared state/verdict types and verdict helpers for the digit-stream comparator
package serial_cmp_pkg;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EQ = 2'd1, S_LT = 2'd2, S_GT = 2'd3} state_t;
   typedef enum logic [1:0] {CMP_EQ = 2'd0, CMP_LT = 2'd1, CMP_GT = 2'd2} verdict_t;

   // Packed as {lt, eq, gt}
   function automatic logic [2:0] verdict_onehot(input verdict_t v);
      case (v)
         CMP_LT:  return 3'b100;
         CMP_GT:  return 3'b001;
         default: return 3'b010;
      endcase
   endfunction

   function automatic state_t verdict_to_state(input verdict_t v);
      case (v)
         CMP_LT:  return S_LT;
         CMP_GT:  return S_GT;
         default: return S_EQ;
      endcase
   endfunction

   function automatic verdict_t state_to_verdict(input state_t s);
      case (s)
         S_LT:    return CMP_LT;
         S_GT:    return CMP_GT;
         default: return CMP_EQ;
      endcase
   endfunction

endpackage

// File: rtl/serial_digit_cmp.sv
// rtl/serial_digit_cmp.sv - combinational compare of one digit pair, unsigned or two's complement
module serial_digit_cmp
   import serial_cmp_pkg::*;
#(
   parameter int DIGIT_W = 1
) (
   input  logic [DIGIT_W-1:0] a_i,
   input  logic [DIGIT_W-1:0] b_i,
   input  logic               signed_i,
   output verdict_t           verdict_o
);

   logic [DIGIT_W-1:0] flip;
   logic [DIGIT_W-1:0] a_m;
   logic [DIGIT_W-1:0] b_m;

   // Inverting the top bit turns a two's complement order into an unsigned one
   always_comb begin
      flip              = '0;
      flip[DIGIT_W-1]   = signed_i;
      a_m               = a_i ^ flip;
      b_m               = b_i ^ flip;
      if (a_m < b_m)      verdict_o = CMP_LT;
      else if (a_m > b_m) verdict_o = CMP_GT;
      else                verdict_o = CMP_EQ;
   end

endmodule

// File: rtl/serial_comparator_digit_stream.sv
// rtl/serial_comparator_digit_stream.sv - framed digit-serial magnitude comparator with valid/ready verdict port
// Optional: define SERIAL_CMP_SIGNED_EN to treat operands as two's complement (sign digit compared signed).
module serial_comparator_digit_stream
   import serial_cmp_pkg::*;
#(
   parameter int DIGIT_W    = 1,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int MAX_DIGITS = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_first,
   input  logic                              in_last,
   input  logic [DIGIT_W-1:0]                a,
   input  logic [DIGIT_W-1:0]                b,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic                              res_lt,
   output logic                              res_eq,
   output logic                              res_gt,
   output logic                              res_err,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   res_digits
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          restart_q, restart_d;
   logic          res_valid_q, res_valid_d;
   logic [2:0]    res_hot_q, res_hot_d;
   logic          res_err_q, res_err_d;
   logic [CW-1:0] res_digits_q, res_digits_d;

   logic          accept, opening, closing, at_max, sign_sel, restart_beat;
   logic [CW-1:0] cnt_beat;
   state_t        base, upd;
   verdict_t      d;

   assign in_ready = ~res_valid_q | res_ready;
   assign accept   = in_valid & in_ready;

   always_comb begin
      opening  = (state_q == S_IDLE) | in_first;
      cnt_beat = opening ? CW'(1) : count_q + CW'(1);
      at_max   = (cnt_beat == CW'(MAX_DIGITS));
      closing  = in_last | at_max;
   end

   // The sign digit is the frame's opening beat MSB-first, its closing beat LSB-first
`ifdef SERIAL_CMP_SIGNED_EN
   assign sign_sel = MSB_FIRST ? opening : closing;
`else
   assign sign_sel = 1'b0;
`endif

   serial_digit_cmp #(.DIGIT_W(DIGIT_W)) u_digit_cmp (
      .a_i       (a),
      .b_i       (b),
      .signed_i  (sign_sel),
      .verdict_o (d)
   );

   always_comb begin
      restart_beat = opening ? (in_first & (state_q != S_IDLE)) : restart_q;
      base         = opening ? S_EQ : state_q;
      if (MSB_FIRST) upd = (base == S_EQ) ? verdict_to_state(d) : base;
      else           upd = (d == CMP_EQ) ? base : verdict_to_state(d);

      state_d      = state_q;
      count_d      = count_q;
      restart_d    = restart_q;
      res_valid_d  = res_valid_q & ~res_ready;
      res_hot_d    = res_hot_q;
      res_err_d    = res_err_q;
      res_digits_d = res_digits_q;

      if (accept) begin
         if (closing) begin
            state_d      = S_IDLE;
            count_d      = '0;
            restart_d    = 1'b0;
            res_valid_d  = 1'b1;
            res_hot_d    = verdict_onehot(state_to_verdict(upd));
            res_err_d    = restart_beat | (at_max & ~in_last);
            res_digits_d = cnt_beat;
         end else begin
            state_d   = upd;
            count_d   = cnt_beat;
            restart_d = restart_beat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         restart_q    <= 1'b0;
         res_valid_q  <= 1'b0;
         res_hot_q    <= 3'b000;
         res_err_q    <= 1'b0;
         res_digits_q <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         restart_q    <= restart_d;
         res_valid_q  <= res_valid_d;
         res_hot_q    <= res_hot_d;
         res_err_q    <= res_err_d;
         res_digits_q <= res_digits_d;
      end
   end

   assign res_valid  = res_valid_q;
   assign res_lt     = res_hot_q[2];
   assign res_eq     = res_hot_q[1];
   assign res_gt     = res_hot_q[0];
   assign res_err    = res_err_q;
   assign res_digits = res_digits_q;

endmodule
